// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipeline stages: the EXE_CMD operation
//   encodings, the execute-stage FSM state type, datapath/register-index
//   widths and the EXE/MEM register layout.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] CMD_ADD   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_AND   = 4'b0100;
    localparam logic [3:0] CMD_OR    = 4'b0101;
    localparam logic [3:0] CMD_NOR   = 4'b0110;
    localparam logic [3:0] CMD_XOR   = 4'b0111;
    localparam logic [3:0] CMD_SLL   = 4'b1000;
    localparam logic [3:0] CMD_SRL   = 4'b1001;
    localparam logic [3:0] CMD_SRA   = 4'b1010;
    localparam logic [3:0] CMD_MUL   = 4'b1100;
    localparam logic [3:0] CMD_MULHU = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} exe_state_t;

    // EXE/MEM register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] st_val;
        logic [REG_W-1:0]  dest;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic [DATA_W-1:0] pc;
    } exe_mem_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Unsigned shift-add multiplier, one partial product per clock.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     start        load a/b, clear accumulator and counter, begin stepping
//     abort        discard any multiply in progress
//     a, b         multiplicand / multiplier (sampled on start)
//     busy         stepping is in progress
//     done         the step being taken this cycle is the last one
//     product      accumulator; holds the full product once stepping ends
module seq_multiplier #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_STEPS - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST)
                busy_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// exe_stage
//   Execute stage: single-cycle ALU plus a sequenced 32-step multiplier,
//   feeding the EXE/MEM output register.
//   Ports:
//     clk, rst, flush                clock, async active-low reset, kill
//     Val1, Val2, Reg2               operands and store data
//     Dest, EXE_CMD, PC              destination, operation, instruction PC
//     MEM_R_EN, MEM_W_EN, WB_EN      memory / write-back controls
//     stall                          freeze upstream while a multiply runs
//     ALU_result .. PC_out           registered EXE/MEM fields
module exe_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int MUL_STEPS = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] Val1,
    input  logic [WIDTH-1:0] Val2,
    input  logic [WIDTH-1:0] Reg2,
    input  logic [REG_W-1:0] Dest,
    input  logic [3:0]       EXE_CMD,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic             WB_EN,
    input  logic [WIDTH-1:0] PC,
    output logic             stall,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ST_val,
    output logic [REG_W-1:0] Dest_out,
    output logic             MEM_R_EN_out,
    output logic             MEM_W_EN_out,
    output logic             WB_EN_out,
    output logic [WIDTH-1:0] PC_out
);

    localparam int SH_W = $clog2(WIDTH);

    exe_state_t         state_q, state_d;
    exe_mem_t           out_q, out_d, pass_w;
    logic [WIDTH-1:0]   alu_res;
    logic [SH_W-1:0]    shamt;
    logic               is_mul;
    logic               mul_start, mul_abort, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign shamt  = Val2[SH_W-1:0];
    assign is_mul = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_MULHU);

    always_comb begin
        alu_res = '0;
        case (EXE_CMD)
            CMD_ADD: alu_res = Val1 + Val2;
            CMD_SUB: alu_res = Val1 - Val2;
            CMD_AND: alu_res = Val1 & Val2;
            CMD_OR:  alu_res = Val1 | Val2;
            CMD_NOR: alu_res = ~(Val1 | Val2);
            CMD_XOR: alu_res = Val1 ^ Val2;
            CMD_SLL: alu_res = Val1 << shamt;
            CMD_SRL: alu_res = Val1 >> shamt;
            CMD_SRA: alu_res = $signed(Val1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Pass-through fields; for a multiply these are taken in DONE, relying
    // on upstream holding them stable while stall is high.
    always_comb begin
        pass_w          = '0;
        pass_w.st_val   = Reg2;
        pass_w.dest     = Dest;
        pass_w.mem_r_en = MEM_R_EN;
        pass_w.mem_w_en = MEM_W_EN;
        pass_w.wb_en    = WB_EN;
        pass_w.pc       = PC;
    end

    seq_multiplier #(
        .WIDTH     (WIDTH),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (Val1),
        .b       (Val2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // out_d defaults to a bubble; only IDLE single-cycle ops and DONE
    // write real contents.
    always_comb begin
        state_d   = state_q;
        out_d     = '0;
        mul_start = 1'b0;
        mul_abort = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            mul_abort = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        out_d        = pass_w;
                        out_d.result = alu_res;
                    end
                end
                BUSY: if (mul_done) state_d = DONE;
                DONE: begin
                    out_d        = pass_w;
                    out_d.result = (EXE_CMD == CMD_MULHU) ? mul_prod[2*WIDTH-1:WIDTH]
                                                          : mul_prod[WIDTH-1:0];
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // mul_busy is high exactly in BUSY (both cleared by flush and reset).
    assign stall = rst && (((state_q == IDLE) && is_mul && !flush) || mul_busy);

    assign ALU_result   = out_q.result;
    assign ST_val       = out_q.st_val;
    assign Dest_out     = out_q.dest;
    assign MEM_R_EN_out = out_q.mem_r_en;
    assign MEM_W_EN_out = out_q.mem_w_en;
    assign WB_EN_out    = out_q.wb_en;
    assign PC_out       = out_q.pc;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipeline. Consumes the ID/EXE register outputs (operands, destination, command, memory/write-back controls), evaluates the single-cycle ALU operations, and runs a 32-step shift-add multiplier for MUL/MULHU. Results go into an internal EXE/MEM output register. While a multiply is in flight the block raises `stall` to freeze IF, ID and the ID/EXE registers.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `MUL_STEPS`, 32, multiplier iterations; must equal `WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `flush` in 1: kill the current EXE instruction.
- `Val1` in 32: operand A.
- `Val2` in 32: operand B.
- `Reg2` in 32: store data.
- `Dest` in 5: destination register.
- `EXE_CMD` in 4: operation.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN` in 1 each: controls.
- `PC` in 32: instruction PC.
- `stall` out 1: freeze upstream (combinational).
- `ALU_result` out 32: registered result.
- `ST_val` out 32: registered store data.
- `Dest_out` out 5: registered destination.
- `MEM_R_EN_out`, `MEM_W_EN_out`, `WB_EN_out` out 1 each: registered controls.
- `PC_out` out 32: registered PC.

## Operation
EXE_CMD encoding:
- 0000 ADD
- 0010 SUB
- 0100 AND
- 0101 OR
- 0110 NOR
- 0111 XOR
- 1000 SLL
- 1001 SRL
- 1010 SRA
- 1100 MUL: low 32 bits of the unsigned product.
- 1101 MULHU: high 32 bits of the unsigned product.
- All other codes: result 0, controls still pass through.

Arithmetic and width rules:
- ADD and SUB are modulo 2^32; no overflow flag.
- Shift amount is `Val2[4:0]`; shifts apply to `Val1`.

FSM states IDLE, BUSY, DONE:
- IDLE with a single-cycle command: output register captures the ALU result and pass-through fields each cycle.
- IDLE with a MUL/MULHU command:
  - Load multiplicand `Val1` into a 64-bit register.
  - Load multiplier `Val2`.
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Go to BUSY.
  - Output register captures a bubble: all three enables 0, data fields 0.
- BUSY:
  - If multiplier bit 0 is set, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; counter +1.
  - Output register captures a bubble each cycle.
  - After the step taken with counter = 31, go to DONE.
- DONE: output register captures the selected product half plus the pass-through fields; go to IDLE.

`stall` = (IDLE and command is MUL/MULHU and not `flush`) or BUSY.

Flush and reset:
- `flush` takes priority in every state: next state IDLE, output register captures a bubble, and any multiply in progress is discarded.
- `rst` low at any time, including mid-multiply: state IDLE, counter 0, accumulator 0, every output register field 0.
- `stall` is 0 while in reset.

## Timing
- Single-cycle ops: result visible on outputs 1 clock after the inputs are presented.
- MUL/MULHU occupies EXE for 34 cycles: 1 IDLE + 32 BUSY + 1 DONE.
  - `stall` is high for exactly 33 consecutive cycles.
  - The result appears after the rising edge that ends DONE.
- Upstream holds its inputs stable while `stall` = 1.
  - The block relies on this: operands are sampled at load, but `Dest`, the control bits and `PC` are sampled in DONE.
- Back-to-back multiplies: the DONE → IDLE edge lets the next instruction in, and its load happens in the following IDLE cycle. No bubble beyond the multiply latency.

## Structure
Shared package `pipeline_pkg` holds:
- The `EXE_CMD` constants.
- `exe_state_t` (IDLE/BUSY/DONE).
- Register-index width 5 and data width 32.

Sub-module `seq_multiplier`:
- Contains the shift-add datapath and counter.
- Ports: `start`, `abort`, `a`, `b`, `busy`, `done`, `product[63:0]`.
- `exe_stage` owns the FSM sequencing, the ALU case statement and the output register.

## Test plan
- Reset mid-multiply: assert `rst` low at BUSY cycle 10 → `stall`=0 and all outputs 0 immediately; after release, ADD 1+1 → `ALU_result`=2.
- ADD/SUB wrap: `Val1`=0xFFFFFFFF, `Val2`=1, ADD → 0x00000000; SUB 0-1 → 0xFFFFFFFF; `Dest`=7 and `WB_EN`=1 pass through one cycle later.
- Shifts: `Val1`=0x80000000, `Val2`=0x21 (amount 1): SRA → 0xC0000000, SRL → 0x40000000, SLL → 0x00000000.
- MUL/MULHU: 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x00000001; MULHU → 0xFFFFFFFE.
  - `stall` high for exactly 33 cycles.
  - Bubbles (`WB_EN_out`=0) during the multiply.
- Flush: pulse `flush` at BUSY cycle 5 → `stall` drops the next cycle, no result written (`WB_EN_out` stays 0), and the next ADD completes normally.
- Back-to-back: MUL 3×5 then MUL 7×9 → results 15 and 63, exactly 34 cycles apart; undefined `EXE_CMD` 1111 → `ALU_result` 0 with `MEM_W_EN_out` passed through.
